// File: rtl/spi_xfer_sequencer.sv
// Streams TX FIFO words through the SPI master register port (write TX, wait READY, read RX) into an RX FIFO.
// Optional SPI_SEQ_IRQ_EN: completion via m_interrupt instead of READY polling, plus a one-time IRQ-enable write.
module spi_xfer_sequencer #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 3,
    parameter int FIFO_AW    = 3,
    parameter int ADDR_READY = 1,
    parameter int ADDR_TX    = 2,
    parameter int ADDR_RX    = 3,
    parameter int TIMEOUT_W  = 16
`ifdef SPI_SEQ_IRQ_EN
    ,
    parameter int ADDR_IRQ_EN = 0
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              err,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_data_in,
    input  logic [DATA_W-1:0] m_data_out,
    output logic              m_sel,
    output logic              m_read,
    output logic              m_write,
    input  logic              m_interrupt
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_POLL  = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_INIT  = 3'd4;
`ifdef SPI_SEQ_IRQ_EN
    localparam logic [2:0] ST_RESET = ST_INIT;
`else
    localparam logic [2:0] ST_RESET = ST_IDLE;
`endif

    logic [DATA_W-1:0]  tx_mem_r [DEPTH];
    logic [FIFO_AW-1:0] tx_wr_ptr_r, tx_rd_ptr_r;
    logic [FIFO_AW:0]   tx_level_r;
    logic [DATA_W-1:0]  rx_mem_r [DEPTH];
    logic [FIFO_AW-1:0] rx_wr_ptr_r, rx_rd_ptr_r;
    logic [FIFO_AW:0]   rx_level_r;

    logic [2:0]           state_r;
    logic [TIMEOUT_W-1:0] timer_r;
    logic                 err_r;
    logic tx_push_s, tx_pop_s, rx_push_s, rx_pop_s, done_s;

    assign tx_ready  = (tx_level_r != FULL_LVL);
    assign tx_push_s = tx_valid && tx_ready;
    // A transfer only starts when its RX word is guaranteed a slot.
    assign tx_pop_s  = (state_r == ST_IDLE) && (tx_level_r != '0) && (rx_level_r != FULL_LVL);
    assign rx_valid  = (rx_level_r != '0);
    assign rx_pop_s  = rx_valid && rx_ready;
    assign rx_push_s = (state_r == ST_READ);
    assign rx_data   = rx_mem_r[rx_rd_ptr_r];
    assign busy      = (state_r != ST_IDLE) || (tx_level_r != '0);
    assign err       = err_r;

`ifdef SPI_SEQ_IRQ_EN
    // timer_r is still zero in the first POLL cycle, which masks the interrupt right after WRITE.
    assign done_s = m_interrupt && (timer_r != '0);
`else
    assign done_s = m_read && m_data_out[0];
    logic unused_irq_s;
    assign unused_irq_s = m_interrupt;
`endif

    // FIFO storage writes
    always_ff @(posedge clk) begin
        if (tx_push_s) tx_mem_r[tx_wr_ptr_r] <= tx_data;
        if (rx_push_s) rx_mem_r[rx_wr_ptr_r] <= m_data_out;
    end

    // FIFO pointers and levels
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr_ptr_r <= '0;
            tx_rd_ptr_r <= '0;
            tx_level_r  <= '0;
            rx_wr_ptr_r <= '0;
            rx_rd_ptr_r <= '0;
            rx_level_r  <= '0;
        end else begin
            if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + 1'b1;
            if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + 1'b1;
            if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + 1'b1;
            if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + 1'b1;
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_level_r <= tx_level_r + 1'b1;
                2'b01:   tx_level_r <= tx_level_r - 1'b1;
                default: tx_level_r <= tx_level_r;
            endcase
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_level_r <= rx_level_r + 1'b1;
                2'b01:   rx_level_r <= rx_level_r - 1'b1;
                default: rx_level_r <= rx_level_r;
            endcase
        end
    end

    // Transfer FSM with registered master-port outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_RESET;
            timer_r   <= '0;
            err_r     <= 1'b0;
            m_address <= '0;
            m_data_in <= '0;
            m_sel     <= 1'b0;
            m_read    <= 1'b0;
            m_write   <= 1'b0;
        end else begin
            m_sel   <= 1'b0;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            if (err_clr) err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (tx_pop_s) begin
                        m_sel     <= 1'b1;
                        m_write   <= 1'b1;
                        m_address <= ADDR_W'(ADDR_TX);
                        m_data_in <= tx_mem_r[tx_rd_ptr_r];
                        state_r   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    timer_r <= '0;
                    state_r <= ST_POLL;
`ifndef SPI_SEQ_IRQ_EN
                    m_sel     <= 1'b1;
                    m_read    <= 1'b1;
                    m_address <= ADDR_W'(ADDR_READY);
`endif
                end
                ST_POLL: begin
                    if (done_s) begin
                        m_sel     <= 1'b1;
                        m_read    <= 1'b1;
                        m_address <= ADDR_W'(ADDR_RX);
                        state_r   <= ST_READ;
                    end else if (&timer_r) begin
                        err_r   <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        timer_r <= timer_r + 1'b1;
`ifndef SPI_SEQ_IRQ_EN
                        m_sel  <= 1'b1;
                        m_read <= 1'b1;
`endif
                    end
                end
                ST_READ: begin
                    state_r <= ST_IDLE;
                end
`ifdef SPI_SEQ_IRQ_EN
                ST_INIT: begin
                    m_sel     <= 1'b1;
                    m_write   <= 1'b1;
                    m_address <= ADDR_W'(ADDR_IRQ_EN);
                    m_data_in <= DATA_W'(1);
                    state_r   <= ST_IDLE;
                end
`endif
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Self-checking bench for spi_xfer_sequencer: table-driven transfers plus hand-written corner sequences,
// against a behavioural SPI master model whose RX word is the last TX word XOR KEY.
module tb_spi_xfer_sequencer;
    localparam logic [31:0] KEY = 32'hB791_5679;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] tx_data = 32'h0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        busy, err;
    logic        err_clr = 1'b0;
    logic [2:0]  m_address;
    logic [31:0] m_data_in, m_data_out;
    logic        m_sel, m_read, m_write, m_interrupt;

    spi_xfer_sequencer dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy), .err(err),
        .err_clr(err_clr), .m_address(m_address), .m_data_in(m_data_in), .m_data_out(m_data_out),
        .m_sel(m_sel), .m_read(m_read), .m_write(m_write), .m_interrupt(m_interrupt)
    );

    always #5 clk = ~clk;

    // Behavioural SPI master: READY rises delay_cfg edges after a TX write, RX read clears it.
    logic        ready_flag = 1'b0;
    logic [31:0] last_wr = 32'h0;
    int          cnt = 0;
    int          delay_cfg = 2;
    logic        never_ready = 1'b0;
    int          ready_reads = 0, rx_reads = 0, wr_count = 0, irq_wr = 0;
    logic [31:0] obs_wr[$];
    logic [31:0] exp_wr[$];
    logic [31:0] exp_rx[$];

    assign m_data_out  = (m_address == 3'd3) ? (last_wr ^ KEY) : {31'b0, ready_flag};
    assign m_interrupt = ready_flag;

    always @(posedge clk) begin
        if (!rst) begin
            ready_flag <= 1'b0;
            cnt        <= 0;
        end else begin
            if (m_sel && m_write && m_address == 3'd2) begin
                obs_wr.push_back(m_data_in);
                last_wr    <= m_data_in;
                ready_flag <= 1'b0;
                cnt        <= delay_cfg;
                wr_count++;
            end else begin
                if (m_sel && m_read && m_address == 3'd3) begin
                    ready_flag <= 1'b0;
                    rx_reads++;
                end else if (cnt == 1 && !never_ready) begin
                    ready_flag <= 1'b1;
                end
                if (cnt > 0) cnt <= cnt - 1;
            end
            if (m_sel && m_read && m_address == 3'd1) ready_reads++;
            if (m_sel && m_write && m_address == 3'd0 && m_data_in == 32'd1) irq_wr++;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] d, input bit expect_rx, output bit acc);
        tx_data  = d;
        tx_valid = 1'b1;
        acc      = tx_ready;
        if (acc) begin
            exp_wr.push_back(d);
            if (expect_rx) exp_rx.push_back(d ^ KEY);
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input int budget, input string name);
        int n = 0;
        while (!rx_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, rx_valid}, 32'd1);
    endtask

    task automatic pop_rx(input string name);
        if (exp_rx.size() == 0) begin
            check({name, "_extra"}, 32'd1, 32'd0);
        end else begin
            check(name, rx_data, exp_rx.pop_front());
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic drain_wr(input string name);
        while (obs_wr.size() > 0) begin
            if (exp_wr.size() == 0) begin
                check({name, "_extra_write"}, obs_wr.pop_front(), 32'hDEAD_BEEF);
            end else begin
                check(name, obs_wr.pop_front(), exp_wr.pop_front());
            end
        end
        check({name, "_missing_writes"}, exp_wr.size(), 32'd0);
    endtask

    typedef struct {
        logic [31:0] data;
        int          delay;
        logic [31:0] exp_rx;
    } vec_t;

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired before test end");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        bit   acc;
        int   n, idx, accepted, w0, r0, rr0;

        vecs[0] = '{32'h0000_0000, 2,  32'hB791_5679};
        vecs[1] = '{32'hFFFF_FFFF, 7,  32'h486E_A986};
        vecs[2] = '{32'h5A5A_5A5A, 15, 32'hEDCB_0C23};
        vecs[3] = '{32'h8000_0001, 3,  32'h3791_5678};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_m_sel", {31'b0, m_sel}, 32'd0);
        check("rst_m_read", {31'b0, m_read}, 32'd0);
        check("rst_m_write", {31'b0, m_write}, 32'd0);
        check("rst_m_address", {29'b0, m_address}, 32'd0);
        check("rst_m_data_in", m_data_in, 32'd0);
        check("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
        check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
`ifndef SPI_SEQ_IRQ_EN
        check("rst_busy", {31'b0, busy}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
`ifdef SPI_SEQ_IRQ_EN
        check("init_irq_en_write", irq_wr, 32'd1);
`else
        check("no_irq_en_write", irq_wr, 32'd0);
`endif

        // First transfer with exact write latency
        delay_cfg = 40;
        rr0 = ready_reads;
        push_word(32'hA5A5_0001, 1'b1, acc);
        check("t1_m_write_k", {31'b0, m_write}, 32'd0);
        @(negedge clk);
        check("t1_m_write_k1", {31'b0, m_write}, 32'd1);
        check("t1_m_address", {29'b0, m_address}, 32'd2);
        check("t1_m_data_in", m_data_in, 32'hA5A5_0001);
        @(negedge clk);
        check("t1_write_drop", {31'b0, m_write}, 32'd0);
`ifndef SPI_SEQ_IRQ_EN
        check("t1_poll_read", {30'b0, m_read, m_sel}, 32'd3);
        check("t1_poll_addr", {29'b0, m_address}, 32'd1);
`endif
        wait_rx(200, "t1_rx_wait");
        check("t1_rx_data", rx_data, 32'h1234_5678);
        check("t1_busy_low", {31'b0, busy}, 32'd0);
        check("t1_rx_reads", rx_reads, 32'd1);
        check("t1_writes", wr_count, 32'd1);
`ifdef SPI_SEQ_IRQ_EN
        check("t1_no_ready_reads", ready_reads - rr0, 32'd0);
`else
        check("t1_ready_reads", {31'b0, 1'((ready_reads - rr0) >= 38)}, 32'd1);
`endif
        pop_rx("t1_pop");
        drain_wr("t1_wr");

        // Table-driven transfers
        for (int i = 0; i < 4; i++) begin
            delay_cfg = vecs[i].delay;
            push_word(vecs[i].data, 1'b1, acc);
            wait_rx(300, "tbl_rx_wait");
            check("tbl_rx_data", rx_data, vecs[i].exp_rx);
            pop_rx("tbl_pop");
        end
        drain_wr("tbl_wr");

        // Back-to-back fill: tx_valid held 10 cycles, RX left unpopped
        delay_cfg = 30;
        w0 = wr_count;
        r0 = rx_reads;
        idx = 0;
        accepted = 0;
        for (int i = 0; i < 10; i++) begin
            push_word(32'h0000_0000 + idx, 1'b1, acc);
            if (acc) begin
                idx++;
                accepted++;
            end
        end
        check("b2b_accepted", accepted, 32'd9);
        check("b2b_tx_full", {31'b0, tx_ready}, 32'd0);
        n = 0;
        while ((rx_reads - r0) < 8 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("b2b_eight_reads", rx_reads - r0, 32'd8);
        repeat (60) @(negedge clk);
        check("rxfull_no_write", wr_count - w0, 32'd8);
        check("rxfull_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 9; i++) begin
            wait_rx(300, "b2b_rx_wait");
            pop_rx("b2b_pop_order");
        end
        check("rxfull_resumed", wr_count - w0, 32'd9);
        drain_wr("b2b_wr");

        // Timeout with err_clr held: set must win, then sticky, then clear
        never_ready = 1'b1;
        rr0 = ready_reads;
        err_clr = 1'b1;
        push_word(32'hCAFE_0009, 1'b0, acc);
        n = 0;
        while (!err && n < 70000) begin
            @(negedge clk);
            n++;
        end
        err_clr = 1'b0;
        check("timeout_err_set", {31'b0, err}, 32'd1);
        check("timeout_idle", {31'b0, busy}, 32'd0);
        check("timeout_no_rx", {31'b0, rx_valid}, 32'd0);
`ifndef SPI_SEQ_IRQ_EN
        check("timeout_polls", {31'b0, 1'((ready_reads - rr0) >= 65535 && (ready_reads - rr0) <= 65537)}, 32'd1);
`endif
        never_ready = 1'b0;
        delay_cfg = 5;
        push_word(32'h0BAD_F00D, 1'b1, acc);
        wait_rx(200, "after_timeout_rx_wait");
        pop_rx("after_timeout_pop");
        check("err_sticky", {31'b0, err}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_cleared", {31'b0, err}, 32'd0);
        drain_wr("timeout_wr");

        // Reset in the middle of POLL with words queued
        delay_cfg = 50;
        for (int i = 0; i < 3; i++) push_word(32'h7700_0000 + i, 1'b1, acc);
        repeat (10) @(negedge clk);
        check("mid_writes", obs_wr.size(), 32'd1);
        if (obs_wr.size() > 0) check("mid_first_word", obs_wr.pop_front(), exp_wr.pop_front());
        exp_wr.delete();
        exp_rx.delete();
        w0 = wr_count;
        rst = 1'b0;
        #1;
        check("mid_rst_strobes", {29'b0, m_sel, m_read, m_write}, 32'd0);
        check("mid_rst_addr", {29'b0, m_address}, 32'd0);
        check("mid_rst_tx_ready", {31'b0, tx_ready}, 32'd1);
        check("mid_rst_rx_valid", {31'b0, rx_valid}, 32'd0);
`ifndef SPI_SEQ_IRQ_EN
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (100) @(negedge clk);
        check("post_rst_no_rx", {31'b0, rx_valid}, 32'd0);
        check("post_rst_no_write", wr_count - w0, 32'd0);
`ifdef SPI_SEQ_IRQ_EN
        check("post_rst_irq_en_write", irq_wr, 32'd2);
`endif

        // Recovery transfer after reset
        delay_cfg = 4;
        push_word(32'h1357_9BDF, 1'b1, acc);
        wait_rx(200, "recover_rx_wait");
        pop_rx("recover_pop");
        drain_wr("recover_wr");
        check("rx_queue_empty", exp_rx.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
